// File: rtl/alu_seq_pkg.sv
// Shared alu_seq definitions: ALU function codes, the captured ALU result record
// and a reference ALU model (only instantiated when ALU_SEQ_CHECK_EN is defined).
package alu_seq_pkg;

    localparam logic [2:0] F_AND     = 3'b000;
    localparam logic [2:0] F_OR      = 3'b001;
    localparam logic [2:0] F_ADD     = 3'b010;
    localparam logic [2:0] F_SLTU_NB = 3'b011;
    localparam logic [2:0] F_ANDN    = 3'b100;
    localparam logic [2:0] F_ORN     = 3'b101;
    localparam logic [2:0] F_SUB     = 3'b110;
    localparam logic [2:0] F_SLT     = 3'b111;

    // The tag travels next to this record; its width is a module parameter.
    typedef struct packed {
        logic [31:0] y;
        logic        zero;
    } alu_res_t;

    function automatic alu_res_t alu_model(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [2:0]  f);
        logic [31:0] bx;
        logic [31:0] s;
        alu_res_t    r;
        bx = f[2] ? ~b : b;
        s  = a + bx + {31'd0, f[2]};
        case (f[1:0])
            2'b00:   r.y = a & bx;
            2'b01:   r.y = a | bx;
            2'b10:   r.y = s;
            default: r.y = {31'd0, s[31]};
        endcase
        r.zero = (r.y == 32'd0);
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// DEPTH x W synchronous FIFO with occupancy count; head is combinational from storage.
// Caller guarantees no push when full and no pop when empty; DEPTH must be a power of two.
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [W-1:0]           push_dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed through count_q.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/alu_seq.sv
// Command sequencer for a combinational ALU: registered issue, capture one cycle later, buffered response.
// Accept-to-rsp_valid is 2 edges; cmd_ready depends only on local occupancy. Optional model: ALU_SEQ_CHECK_EN.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_f,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_f,
    input  logic [31:0]      alu_y,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_y,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      op_count,
    output logic             chk_mismatch
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        alu_res_t         res;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic             init_q;
    logic             issue_v_q, issue_v_d;
    logic [31:0]      alu_a_q, alu_b_q;
    logic [2:0]       alu_f_q;
    logic [TAG_W-1:0] issue_tag_q;
    logic [15:0]      op_count_q, op_count_d;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      occupancy;
    logic             cmd_fire, rsp_fire;
    entry_t           push_ent, head_ent;

    // The issue slot counts as occupied so a captured result always has a FIFO entry.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, issue_v_q};
    assign cmd_ready = init_q && (occupancy < (CW+1)'(DEPTH));
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_valid = (fifo_count != '0);
    assign rsp_fire  = rsp_valid && rsp_ready;

    assign issue_v_d  = cmd_fire;
    assign op_count_d = rsp_fire ? op_count_q + 16'd1 : op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b0;
            issue_v_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= '0;
            issue_tag_q <= '0;
            op_count_q  <= '0;
        end else begin
            init_q     <= 1'b1;
            issue_v_q  <= issue_v_d;
            op_count_q <= op_count_d;
            if (cmd_fire) begin
                alu_a_q     <= cmd_a;
                alu_b_q     <= cmd_b;
                alu_f_q     <= cmd_f;
                issue_tag_q <= cmd_tag;
            end
        end
    end

    assign push_ent = {alu_y, alu_zero, issue_tag_q};

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (issue_v_q),
        .push_dat_i (push_ent),
        .pop_i      (rsp_fire),
        .head_dat_o (head_ent),
        .count_o    (fifo_count)
    );

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_f    = alu_f_q;
    // Unloaded storage is hidden so an empty response port reads as zero.
    assign rsp_y    = rsp_valid ? head_ent.res.y    : '0;
    assign rsp_zero = rsp_valid ? head_ent.res.zero : 1'b0;
    assign rsp_tag  = rsp_valid ? head_ent.tag      : '0;
    assign op_count = op_count_q;

`ifdef ALU_SEQ_CHECK_EN
    alu_res_t model_res;
    logic     chk_q;

    assign model_res = alu_model(alu_a_q, alu_b_q, alu_f_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= 1'b0;
        end else if (issue_v_q && (model_res != {alu_y, alu_zero})) begin
            chk_q <= 1'b1;
        end
    end

    assign chk_mismatch = chk_q;
`else
    assign chk_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU stub whose result bit 0 can be flipped on demand.
module tb_alu_seq;
    import alu_seq_pkg::*;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic CHK_BUILT = 1'b1;
`else
    localparam logic CHK_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [2:0]  cmd_f;
    logic [3:0]  cmd_tag;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_f;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_y;
    logic        rsp_zero;
    logic [3:0]  rsp_tag;
    logic [15:0] op_count;
    logic        chk_mismatch;
    logic        flip;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] y;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
        logic [31:0] t;
        logic [31:0] r;
        r = '0;
        case (f)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a + b;
            3'd3: begin t = a + b; r = {31'd0, t[31]}; end
            3'd4: r = a & ~b;
            3'd5: r = a | ~b;
            3'd6: r = a - b;
            default: begin t = a - b; r = {31'd0, t[31]}; end
        endcase
        return r;
    endfunction

    assign alu_y    = ref_alu(alu_a, alu_b, alu_f) ^ {31'd0, flip};
    assign alu_zero = (alu_y == 32'd0);

    alu_seq #(.DEPTH(4), .TAG_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_f        (cmd_f),
        .cmd_tag      (cmd_tag),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_f        (alu_f),
        .alu_y        (alu_y),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_y        (rsp_y),
        .rsp_zero     (rsp_zero),
        .rsp_tag      (rsp_tag),
        .op_count     (op_count),
        .chk_mismatch (chk_mismatch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                         input logic [3:0] tag);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_f     = f;
        cmd_tag   = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_f = '0; cmd_tag = '0;
        rsp_ready = 1'b0; flip = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got=%0b exp=0", cmd_ready); else n_pass++;
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); else n_pass++;
        n_checks++;
        if ({alu_a, alu_b, alu_f} !== 67'd0) $display("FAIL reset_alu_ops got=%h exp=0", {alu_a, alu_b, alu_f}); else n_pass++;
        n_checks++;
        if ({rsp_y, rsp_zero, rsp_tag} !== 37'd0) $display("FAIL reset_rsp got=%h exp=0", {rsp_y, rsp_zero, rsp_tag}); else n_pass++;
        n_checks++;
        if ({op_count, chk_mismatch} !== 17'd0) $display("FAIL reset_cnt_chk got=%h exp=0", {op_count, chk_mismatch}); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL ready_before_clk got=%0b exp=0", cmd_ready); else n_pass++;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL ready_after_clk got=%0b exp=1", cmd_ready); else n_pass++;
    endtask

    task automatic test_add();
        rsp_ready = 1'b1;
        drive(32'd5, 32'd7, F_ADD, 4'd3);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL add_ready got=%0b exp=1", cmd_ready); else n_pass++;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7)
            $display("FAIL add_issue got=v%0b a=%0d b=%0d exp=v0 a=5 b=7", rsp_valid, alu_a, alu_b);
        else n_pass++;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'd12 || rsp_zero !== 1'b0 || rsp_tag !== 4'd3)
            $display("FAIL add_rsp got=v%0b y=%0d z=%0b t=%0d exp=v1 y=12 z=0 t=3", rsp_valid, rsp_y, rsp_zero, rsp_tag);
        else n_pass++;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || op_count !== 16'd1)
            $display("FAIL add_pop got=v%0b cnt=%0d exp=v0 cnt=1", rsp_valid, op_count);
        else n_pass++;
        n_checks++;
        if (alu_a !== 32'd5 || alu_f !== F_ADD) $display("FAIL alu_hold got=a%0d f%0d exp=a5 f2", alu_a, alu_f); else n_pass++;
    endtask

    task automatic test_sub_slt();
        rsp_ready = 1'b1;
        drive(32'd9, 32'd9, F_SUB, 4'd1);
        tick();
        drive(32'hFFFF_FFFF, 32'd1, F_SLT, 4'd2);
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'd0 || rsp_zero !== 1'b1 || rsp_tag !== 4'd1)
            $display("FAIL sub_rsp got=v%0b y=%0d z=%0b t=%0d exp=v1 y=0 z=1 t=1", rsp_valid, rsp_y, rsp_zero, rsp_tag);
        else n_pass++;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'd1 || rsp_zero !== 1'b0 || rsp_tag !== 4'd2)
            $display("FAIL slt_rsp got=v%0b y=%0d z=%0b t=%0d exp=v1 y=1 z=0 t=2", rsp_valid, rsp_y, rsp_zero, rsp_tag);
        else n_pass++;
        tick();
        n_checks++;
        if (op_count !== 16'd3) $display("FAIL sub_slt_count got=%0d exp=3", op_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(32'd100 + 32'(accepted), 32'd1, F_ADD, 4'(accepted));
            if (cmd_ready === 1'b1) begin
                tick();
                accepted++;
            end else begin
                tick();
            end
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (accepted != 4) $display("FAIL bp_accepted got=%0d exp=4", accepted); else n_pass++;
        tick();
        tick();
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL bp_full_ready got=%0b exp=0", cmd_ready); else n_pass++;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0 || rsp_y !== 32'd101)
            $display("FAIL bp_hold got=v%0b t=%0d y=%0d exp=v1 t=0 y=101", rsp_valid, rsp_tag, rsp_y);
        else n_pass++;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'(i) || rsp_y !== 32'd101 + 32'(i))
                $display("FAIL bp_order[%0d] got=v%0b t=%0d y=%0d exp=v1 t=%0d y=%0d",
                         i, rsp_valid, rsp_tag, rsp_y, i, 101 + i);
            else n_pass++;
            tick();
            if (i == 0) begin
                n_checks++;
                if (cmd_ready !== 1'b1) $display("FAIL bp_reready got=%0b exp=1", cmd_ready); else n_pass++;
            end
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || op_count !== 16'd7)
            $display("FAIL bp_drain got=v%0b cnt=%0d exp=v0 cnt=7", rsp_valid, op_count);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic stale = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'd1, 32'd2, F_OR, 4'd8 + 4'(i));
            tick();
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd8) $display("FAIL midop_prefill got=v%0b t=%0d exp=v1 t=8", rsp_valid, rsp_tag); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, cmd_ready, rsp_y, rsp_tag, op_count} !== '0 || {alu_a, alu_b, alu_f} !== 67'd0)
            $display("FAIL midop_reset got=v%0b r%0b y=%0d t=%0d cnt=%0d a=%0d exp=all0",
                     rsp_valid, cmd_ready, rsp_y, rsp_tag, op_count, alu_a);
        else n_pass++;
        tick();
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0) stale = 1'b1;
        end
        n_checks++;
        if (stale !== 1'b0 || op_count !== 16'd0) $display("FAIL midop_stale got=stale%0b cnt=%0d exp=stale0 cnt=0", stale, op_count); else n_pass++;
    endtask

    task automatic test_streaming();
        exp_t q[$];
        exp_t e;
        int   sent = 0, got = 0, stalls = 0;
        logic [31:0] a, b, y;
        logic [2:0]  f;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && got < 100; cyc++) begin
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL stream_extra got t=%0d y=%h exp=no response", rsp_tag, rsp_y);
                end else begin
                    e = q.pop_front();
                    if ({rsp_y, rsp_zero, rsp_tag} !== e)
                        $display("FAIL stream[%0d] got y=%h z=%0b t=%0d exp y=%h z=%0b t=%0d",
                                 got, rsp_y, rsp_zero, rsp_tag, e.y, e.zero, e.tag);
                    else n_pass++;
                end
                got++;
            end
            if (sent < 100) begin
                a = $urandom;
                b = (sent % 7 == 0) ? a : $urandom;
                f = 3'($urandom_range(0, 7));
                drive(a, b, f, 4'(sent));
                if (cmd_ready === 1'b1) begin
                    y = ref_alu(a, b, f);
                    q.push_back({y, y == 32'd0, 4'(sent)});
                    sent++;
                end else begin
                    stalls++;
                end
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (stalls != 0 || got != 100) $display("FAIL stream_rate got stalls=%0d rsps=%0d exp stalls=0 rsps=100", stalls, got); else n_pass++;
        n_checks++;
        if (op_count !== 16'd100 || chk_mismatch !== 1'b0)
            $display("FAIL stream_count got cnt=%0d chk=%0b exp cnt=100 chk=0", op_count, chk_mismatch);
        else n_pass++;
    endtask

    task automatic test_check();
        logic        exp_chk;
        logic [31:0] exp_y;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(32'd1 + 32'(k), 32'd2, F_ADD, 4'(k));
            tick();
            cmd_valid = 1'b0;
            flip = (k == 2);
            tick();
            flip = 1'b0;
            exp_y   = (k == 2) ? 32'd4 : 32'd3 + 32'(k);
            exp_chk = (k == 2) ? CHK_BUILT : 1'b0;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_y !== exp_y || rsp_tag !== 4'(k))
                $display("FAIL chk_rsp[%0d] got v%0b y=%0d t=%0d exp v1 y=%0d t=%0d", k, rsp_valid, rsp_y, rsp_tag, exp_y, k);
            else n_pass++;
            n_checks++;
            if (chk_mismatch !== exp_chk) $display("FAIL chk_flag[%0d] got=%0b exp=%0b", k, chk_mismatch, exp_chk); else n_pass++;
            tick();
        end
        repeat (3) tick();
        n_checks++;
        if (chk_mismatch !== CHK_BUILT) $display("FAIL chk_sticky got=%0b exp=%0b", chk_mismatch, CHK_BUILT); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (chk_mismatch !== 1'b0) $display("FAIL chk_reset got=%0b exp=0", chk_mismatch); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_backpressure();
        test_reset_midop();
        test_streaming();
        test_check();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
